// File: rtl/ysyx_22040895_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040895_mem_arbiter_pkg
// Brief    : State/owner encodings and the fair-pick helper for the IF/LS
//            memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_22040895_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_e;

    localparam logic ARB_OWNER_IF = 1'b0;
    localparam logic ARB_OWNER_LS = 1'b1;

    // On a tie the side that did not own the port last time wins.
    function automatic logic arb_pick(input logic if_req,
                                      input logic ls_req,
                                      input logic last_owner);
        if (if_req && ls_req) begin
            return ~last_owner;
        end else if (ls_req) begin
            return ARB_OWNER_LS;
        end else begin
            return ARB_OWNER_IF;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22040895_arb_timer.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040895_arb_timer
// Brief    : Saturating transaction watchdog; only built when
//            YSYX_22040895_ARB_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef YSYX_22040895_ARB_TIMEOUT_EN
module ysyx_22040895_arb_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int                 c_cnt_w = $clog2(LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(LIMIT);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + c_one;
        end
    end

    assign expired = (r_count == c_limit);

endmodule
`endif
`default_nettype wire

// File: rtl/ysyx_22040895_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040895_mem_arbiter
// Brief    : Shares one memory port between IF and LS, one transaction at a
//            time, alternating on ties. Watchdog: YSYX_22040895_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040895_mem_arbiter
    import ysyx_22040895_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_err_o,
    input  logic                ls_req_i,
    input  logic                ls_we_i,
    input  logic [ADDR_W-1:0]   ls_addr_i,
    input  logic [DATA_W-1:0]   ls_wdata_i,
    input  logic [DATA_W/8-1:0] ls_wmask_i,
    output logic                ls_gnt_o,
    output logic                ls_rvalid_o,
    output logic [DATA_W-1:0]   ls_rdata_o,
    output logic                ls_err_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wmask_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                busy_o,
    output logic                owner_o
);

    arb_state_e          r_state;
    arb_state_e          w_state_next;
    logic                r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wmask;

    logic w_any_req;
    logic w_winner;
    logic w_accept;
    logic w_active;
    logic w_timeout;
    logic w_resp_mem;
    logic w_resp_to;
    logic w_resp;

    assign w_any_req = if_req_i | ls_req_i;
    assign w_winner  = arb_pick(if_req_i, ls_req_i, r_owner);
    // Gated by rst so grants stay low while reset is held.
    assign w_accept  = rst & (r_state == ARB_IDLE) & w_any_req;
    assign w_active  = (r_state == ARB_REQ) | (r_state == ARB_WAIT);

`ifdef YSYX_22040895_ARB_TIMEOUT_EN
    ysyx_22040895_arb_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_accept),
        .enable  (w_active),
        .expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
    if (TIMEOUT_CYC < 1) begin : g_timeout_cfg_unused
    end
`endif

    // A genuine response in the same cycle as expiry is delivered normally.
    assign w_resp_mem = (r_state == ARB_WAIT) & mem_rvalid_i;
    assign w_resp_to  = w_active & w_timeout & ~w_resp_mem;
    assign w_resp     = w_resp_mem | w_resp_to;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
            r_owner <= ARB_OWNER_IF;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_owner <= w_winner;
                if (w_winner == ARB_OWNER_LS) begin
                    r_we    <= ls_we_i;
                    r_addr  <= ls_addr_i;
                    r_wdata <= ls_wdata_i;
                    r_wmask <= ls_wmask_i;
                end else begin
                    r_we    <= 1'b0;
                    r_addr  <= if_addr_i;
                    r_wdata <= '0;
                    r_wmask <= '1;
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if_gnt_o     = 1'b0;
        ls_gnt_o     = 1'b0;
        if_rvalid_o  = 1'b0;
        ls_rvalid_o  = 1'b0;
        if_rdata_o   = '0;
        ls_rdata_o   = '0;
        if_err_o     = 1'b0;
        ls_err_o     = 1'b0;

        case (r_state)
            ARB_IDLE: begin
                if (w_accept) begin
                    w_state_next = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (w_resp_to) begin
                    w_state_next = ARB_IDLE;
                end else if (mem_gnt_i) begin
                    w_state_next = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (w_resp) begin
                    w_state_next = ARB_IDLE;
                end
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase

        if_gnt_o = w_accept & (w_winner == ARB_OWNER_IF);
        ls_gnt_o = w_accept & (w_winner == ARB_OWNER_LS);

        if (w_resp) begin
            if (r_owner == ARB_OWNER_LS) begin
                ls_rvalid_o = 1'b1;
                ls_err_o    = w_resp_to;
                if (w_resp_mem && !r_we) begin
                    ls_rdata_o = mem_rdata_i;
                end
            end else begin
                if_rvalid_o = 1'b1;
                if_err_o    = w_resp_to;
                if (w_resp_mem) begin
                    if_rdata_o = mem_rdata_i;
                end
            end
        end
    end

    assign mem_req_o   = (r_state == ARB_REQ);
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign mem_wmask_o = r_wmask;
    assign busy_o      = (r_state != ARB_IDLE);
    assign owner_o     = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040895_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22040895_mem_arbiter
// Brief    : Directed self-checking bench for the IF/LS memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040895_mem_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    logic                clk;
    logic                rst;
    logic                if_req_i;
    logic [ADDR_W-1:0]   if_addr_i;
    logic                if_gnt_o;
    logic                if_rvalid_o;
    logic [DATA_W-1:0]   if_rdata_o;
    logic                if_err_o;
    logic                ls_req_i;
    logic                ls_we_i;
    logic [ADDR_W-1:0]   ls_addr_i;
    logic [DATA_W-1:0]   ls_wdata_i;
    logic [DATA_W/8-1:0] ls_wmask_i;
    logic                ls_gnt_o;
    logic                ls_rvalid_o;
    logic [DATA_W-1:0]   ls_rdata_o;
    logic                ls_err_o;
    logic                mem_req_o;
    logic                mem_we_o;
    logic [ADDR_W-1:0]   mem_addr_o;
    logic [DATA_W-1:0]   mem_wdata_o;
    logic [DATA_W/8-1:0] mem_wmask_o;
    logic                mem_gnt_i;
    logic                mem_rvalid_i;
    logic [DATA_W-1:0]   mem_rdata_i;
    logic                busy_o;
    logic                owner_o;

    int n_checks = 0;
    int n_errors = 0;

    ysyx_22040895_mem_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_gnt_o     (if_gnt_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .if_err_o     (if_err_o),
        .ls_req_i     (ls_req_i),
        .ls_we_i      (ls_we_i),
        .ls_addr_i    (ls_addr_i),
        .ls_wdata_i   (ls_wdata_i),
        .ls_wmask_i   (ls_wmask_i),
        .ls_gnt_o     (ls_gnt_o),
        .ls_rvalid_o  (ls_rvalid_o),
        .ls_rdata_o   (ls_rdata_o),
        .ls_err_o     (ls_err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wmask_o  (mem_wmask_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .busy_o       (busy_o),
        .owner_o      (owner_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b0;
        if_req_i     = 1'b0;
        if_addr_i    = '0;
        ls_req_i     = 1'b0;
        ls_we_i      = 1'b0;
        ls_addr_i    = '0;
        ls_wdata_i   = '0;
        ls_wmask_i   = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;

        // Reset state
        tick();
        mid();
        check("rst_busy",  busy_o,      0);
        check("rst_owner", owner_o,     0);
        check("rst_req",   mem_req_o,   0);
        check("rst_addr",  mem_addr_o,  0);
        check("rst_wmask", mem_wmask_o, 0);
        tick();
        rst = 1'b1;

        // 1: lone IF read
        if_req_i  = 1'b1;
        if_addr_i = 64'h8000_0000;
        mid();
        check("t1_if_gnt", if_gnt_o, 1);
        check("t1_ls_gnt", ls_gnt_o, 0);
        check("t1_req_idle", mem_req_o, 0);
        tick();
        if_req_i  = 1'b0;
        if_addr_i = '0;
        mem_gnt_i = 1'b1;
        mid();
        check("t1_mem_req",   mem_req_o,   1);
        check("t1_mem_addr",  mem_addr_o,  64'h8000_0000);
        check("t1_mem_we",    mem_we_o,    0);
        check("t1_mem_wmask", mem_wmask_o, 8'hFF);
        check("t1_gnt_low",   if_gnt_o,    0);
        tick();
        mem_gnt_i = 1'b0;
        mid();
        check("t1_wait_busy",   busy_o,      1);
        check("t1_wait_rvalid", if_rvalid_o, 0);
        check("t1_wait_memreq", mem_req_o,   0);
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'h13;
        mid();
        check("t1_if_rvalid", if_rvalid_o, 1);
        check("t1_if_rdata",  if_rdata_o,  64'h13);
        check("t1_if_err",    if_err_o,    0);
        check("t1_ls_rvalid", ls_rvalid_o, 0);
        check("t1_ls_rdata",  ls_rdata_o,  0);
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        mid();
        check("t1_idle_busy",   busy_o,      0);
        check("t1_idle_rvalid", if_rvalid_o, 0);

        // 2: simultaneous requests after reset -> LS first, then IF
        rst = 1'b0;
        tick();
        rst = 1'b1;
        if_req_i  = 1'b1;
        if_addr_i = 64'h8000_0100;
        ls_req_i  = 1'b1;
        ls_we_i   = 1'b0;
        ls_addr_i = 64'h8000_0200;
        mid();
        check("t2_ls_gnt_first", ls_gnt_o, 1);
        check("t2_if_gnt_first", if_gnt_o, 0);
        tick();
        ls_req_i  = 1'b0;
        mem_gnt_i = 1'b1;
        mid();
        check("t2_owner_ls",  owner_o,    1);
        check("t2_addr_ls",   mem_addr_o, 64'h8000_0200);
        check("t2_if_gnt_req", if_gnt_o,  0);
        tick();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'h1111;
        mid();
        check("t2_ls_rvalid", ls_rvalid_o, 1);
        check("t2_ls_rdata",  ls_rdata_o,  64'h1111);
        check("t2_if_rvalid", if_rvalid_o, 0);
        check("t2_if_rdata",  if_rdata_o,  0);
        tick();
        mem_rvalid_i = 1'b0;
        mid();
        check("t2_if_gnt_second", if_gnt_o, 1);
        check("t2_ls_gnt_second", ls_gnt_o, 0);
        tick();
        if_req_i  = 1'b0;
        mem_gnt_i = 1'b1;
        mid();
        check("t2_owner_if", owner_o,    0);
        check("t2_addr_if",  mem_addr_o, 64'h8000_0100);
        tick();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'h2222;
        mid();
        check("t2_if_rvalid2", if_rvalid_o, 1);
        check("t2_if_rdata2",  if_rdata_o,  64'h2222);
        tick();
        mem_rvalid_i = 1'b0;

        // 3: LS write
        ls_req_i   = 1'b1;
        ls_we_i    = 1'b1;
        ls_addr_i  = 64'h8000_1000;
        ls_wdata_i = 64'hDEAD_BEEF;
        ls_wmask_i = 8'h0F;
        mid();
        check("t3_ls_gnt", ls_gnt_o, 1);
        tick();
        ls_req_i   = 1'b0;
        ls_we_i    = 1'b0;
        ls_wdata_i = '0;
        mem_gnt_i  = 1'b1;
        mid();
        check("t3_mem_we",    mem_we_o,    1);
        check("t3_mem_addr",  mem_addr_o,  64'h8000_1000);
        check("t3_mem_wdata", mem_wdata_o, 64'hDEAD_BEEF);
        check("t3_mem_wmask", mem_wmask_o, 8'h0F);
        tick();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'hCAFE_F00D;
        mid();
        check("t3_ls_rvalid", ls_rvalid_o, 1);
        check("t3_ls_rdata",  ls_rdata_o,  0);
        check("t3_ls_err",    ls_err_o,    0);
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;

        // 4: grant withheld for 5 cycles; inputs and early rvalid ignored
        if_req_i  = 1'b1;
        if_addr_i = 64'h8000_0040;
        mid();
        check("t4_if_gnt", if_gnt_o, 1);
        tick();
        if_addr_i = 64'h0;
        ls_req_i  = 1'b1;
        ls_addr_i = 64'h1234;
        for (int i = 0; i < 5; i++) begin
            mem_rvalid_i = (i == 2);
            mem_rdata_i  = 64'hBAD;
            mid();
            check("t4_mem_req",   mem_req_o,   1);
            check("t4_mem_addr",  mem_addr_o,  64'h8000_0040);
            check("t4_if_gnt",    if_gnt_o,    0);
            check("t4_ls_gnt",    ls_gnt_o,    0);
            check("t4_if_rvalid", if_rvalid_o, 0);
            tick();
        end
        mem_rvalid_i = 1'b0;
        if_req_i     = 1'b0;
        ls_req_i     = 1'b0;
        mem_gnt_i    = 1'b1;
        tick();
        mem_gnt_i = 1'b0;

        // 5: reset while in WAIT abandons the transaction
        mid();
        check("t5_busy_wait", busy_o, 1);
        #2;
        rst          = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'h55;
        #1;
        check("t5_rst_busy",   busy_o,      0);
        check("t5_rst_req",    mem_req_o,   0);
        check("t5_rst_addr",   mem_addr_o,  0);
        check("t5_rst_wmask",  mem_wmask_o, 0);
        check("t5_rst_rvalid", if_rvalid_o, 0);
        check("t5_rst_rdata",  if_rdata_o,  0);
        tick();
        mid();
        check("t5_held_rvalid", if_rvalid_o, 0);
        tick();
        rst = 1'b1;
        mid();
        check("t5_post_rvalid", if_rvalid_o, 0);
        check("t5_post_busy",   busy_o,      0);
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;

`ifdef YSYX_22040895_ARB_TIMEOUT_EN
        // 6: memory never responds -> error completion 8 cycles after REQ entry
        if_req_i  = 1'b1;
        if_addr_i = 64'h8000_0080;
        mid();
        check("t6_if_gnt", if_gnt_o, 1);
        tick();
        if_req_i  = 1'b0;
        mem_gnt_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            mid();
            check("t6_no_rvalid", if_rvalid_o, 0);
            tick();
            mem_gnt_i = 1'b0;
        end
        mid();
        check("t6_to_rvalid", if_rvalid_o, 1);
        check("t6_to_err",    if_err_o,    1);
        check("t6_to_rdata",  if_rdata_o,  0);
        check("t6_to_ls",     ls_rvalid_o, 0);
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'h77;
        mid();
        check("t6_late_rvalid", if_rvalid_o, 0);
        check("t6_late_busy",   busy_o,      0);
        check("t6_late_req",    mem_req_o,   0);
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
